ltpi_smbus_channel_arbiter: RTL

Round-robin arbiter and sequencer sharing one LTPI SMBus relay engine among several SMBus requesters (local BMC controllers and LTPI-tunnelled remote channels). Grants one requester at a time, pulses the engine start, waits for completion, enforces an SMBus bus-free gap between transactions, and optionally aborts hung transactions with a watchdog. Sits between the per-channel SMBus front-ends and the single LTPI SMBus relay datapath.

---
 rtl/ltpi_smbus_arb_pkg.sv | 15 +
 rtl/ltpi_rr_select.sv | 37 +++
 rtl/ltpi_smbus_channel_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ltpi_smbus_arb_pkg.sv
// Shared types and defaults for the LTPI SMBus channel arbiter.
// Holds the sequencer state encoding and the default timing constants.
package ltpi_smbus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        ACTIVE  = 2'd2,
        RELEASE = 2'd3
    } arb_state_e;

    localparam int DEF_BUS_FREE_CYCLES = 16;
    localparam int DEF_TIMEOUT_CYCLES  = 4096;

endpackage

// File: rtl/ltpi_rr_select.sv
// Combinational round-robin pick: first set request bit at or above rr_ptr,
// wrapping to the lowest set bit when nothing at or above the pointer is pending.
module ltpi_rr_select #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]         sel_onehot,
    output logic [$clog2(NUM_REQ)-1:0] sel_idx,
    output logic                       any_valid
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] upper_req;
    logic [NUM_REQ-1:0] pick_req;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_upper
        assign upper_req[gi] = req[gi] & (IDX_W'(gi) >= rr_ptr);
    end

    // Requests at or above the pointer take priority; otherwise wrap around.
    assign pick_req  = (|upper_req) ? upper_req : req;
    assign any_valid = |req;

    always_comb begin
        sel_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pick_req[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    assign sel_onehot = any_valid ? (NUM_REQ'(1) << sel_idx) : '0;

endmodule

// File: rtl/ltpi_smbus_channel_arbiter.sv
// Round-robin arbiter/sequencer sharing one LTPI SMBus relay engine among NUM_REQ requesters.
// Optional watchdog abort is built when LTPI_SMBUS_ARB_TIMEOUT_EN is defined.
module ltpi_smbus_channel_arbiter
    import ltpi_smbus_arb_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int BUS_FREE_CYCLES = DEF_BUS_FREE_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       eng_start,
    input  logic                       eng_done,
    output logic                       eng_abort,
    output logic                       timeout_err,
    output logic                       busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int BF_W  = $clog2(BUS_FREE_CYCLES + 1);
    localparam logic [BF_W-1:0]  BF_LAST  = BF_W'(BUS_FREE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("NUM_REQ must be in 2..8");
    end
    if (BUS_FREE_CYCLES < 1) begin : g_bad_bus_free
        $error("BUS_FREE_CYCLES must be at least 1");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   grant_id_q, grant_id_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BF_W-1:0]    bf_cnt_q, bf_cnt_d;
    logic               eng_start_q, eng_start_d;
    logic               busy_q, busy_d;
    logic               timeout_hit;

    logic [NUM_REQ-1:0] sel_onehot;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_valid;

    ltpi_rr_select #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_select (
        .req        (req),
        .rr_ptr     (rr_ptr_q),
        .sel_onehot (sel_onehot),
        .sel_idx    (sel_idx),
        .any_valid  (sel_valid)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        bf_cnt_d   = bf_cnt_q;
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    grant_d    = sel_onehot;
                    grant_id_d = sel_idx;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                state_d = ACTIVE;
            end
            ACTIVE: begin
                // Grant drops on the same edge that sees completion or timeout.
                if (eng_done || timeout_hit) begin
                    state_d  = RELEASE;
                    grant_d  = '0;
                    bf_cnt_d = '0;
                    rr_ptr_d = (grant_id_q == IDX_LAST) ? '0 : grant_id_q + 1'b1;
                end
            end
            RELEASE: begin
                if (bf_cnt_q == BF_LAST) begin
                    state_d = IDLE;
                end else begin
                    bf_cnt_d = bf_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        eng_start_d = (state_q == GRANT);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_id_q  <= '0;
            rr_ptr_q    <= '0;
            bf_cnt_q    <= '0;
            eng_start_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_id_q  <= grant_id_d;
            rr_ptr_q    <= rr_ptr_d;
            bf_cnt_q    <= bf_cnt_d;
            eng_start_q <= eng_start_d;
            busy_q      <= busy_d;
        end
    end

`ifdef LTPI_SMBUS_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            eng_abort_q, eng_abort_d;

    // Counts ACTIVE cycles already elapsed; the TIMEOUT_CYCLES-th cycle fires the abort.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_q == GRANT) begin
            to_cnt_d = '0;
        end else if (state_q == ACTIVE && to_cnt_q != TO_MAX) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    assign timeout_hit = (state_q == ACTIVE) && (to_cnt_q == TO_LAST);
    assign eng_abort_d = timeout_hit && !eng_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q    <= '0;
            eng_abort_q <= 1'b0;
        end else begin
            to_cnt_q    <= to_cnt_d;
            eng_abort_q <= eng_abort_d;
        end
    end

    assign eng_abort   = eng_abort_q;
    assign timeout_err = eng_abort_q;
`else
    assign timeout_hit = 1'b0;
    assign eng_abort   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign grant     = grant_q;
    assign grant_id  = grant_id_q;
    assign eng_start = eng_start_q;
    assign busy      = busy_q;

endmodule
